mux_sel_arbiter: RTL
====================

// Module: mux_sel_arbiter
// PURPOSE
//  Round-robin arbiter for one shared-memory output mux in mux_ctrl.
//  Selects one of N requesting ports and drives a registered one-hot grant
//  vector that steers the mux. The same vector feeds an xor_tree of width N.
//  The xor_tree returns the vector's parity, and the arbiter uses it as a
//  one-hot integrity check.
// PARAMETERS
//  N        8   requesting ports; power of two, >=2 (same N as the paired xor_tree)
//  IDX_W    3   $clog2(N); width of grant_idx
//  MAX_HOLD 16  max consecutive grant cycles while others wait; 0 = unlimited
// PORTS
//  clk          in   1      single clock, rising edge
//  rst          in   1      synchronous, active-high reset
//  req          in   N      per-port request; held high for the whole transfer
//  done         in   N      per-port end-of-transfer pulse; only holder's bit is used
//  grant        out  N      registered one-hot mux select; all zero when idle
//  grant_idx    out  IDX_W  binary index of the holder; valid when grant_valid=1
//  grant_valid  out  1      1 while a grant is held
//  grant_parity in   1      XOR of grant, returned combinationally by xor_tree
//  parity_err   out  1      sticky integrity error flag
// BEHAVIOUR
//  Reset (rst high at an edge): state=IDLE, grant=0, grant_idx=0, grant_valid=0,
//   ptr=0, hold_cnt=0, parity_err=0. Reset wins over every other event,
//   including in the middle of a grant.
//  FSM states are IDLE and GRANT. All outputs are registered.
//  IDLE:
//   - If |req=1, pick the first set req bit scanning ptr, ptr+1, ... (mod N).
//   - At that edge: grant=onehot(w), grant_idx=w, grant_valid=1, hold_cnt=0, go to GRANT.
//   - Latency: grant is visible in the cycle after req is first sampled high.
//  GRANT (holder h):
//   - Release when any of these is sampled at an edge:
//     done[h]=1; or req[h]=0; or (MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 && others pending).
//     "Others pending" means |(req & ~onehot(h)) = 1.
//   - On release: grant=0, grant_valid=0, ptr=(h+1) mod N, hold_cnt=0, go to IDLE.
//     grant_idx keeps its value.
//   - Otherwise hold_cnt increments, saturating at MAX_HOLD-1.
//     If no other port is pending, the holder keeps the grant past MAX_HOLD.
//  Inter-grant gap:
//   - There is always exactly one idle cycle (grant=0) between successive grants.
//   - The mux therefore never switches between two ports in one edge.
//  Simultaneous events:
//   - done[h] and req[h] both drop at the same edge: a single release.
//   - A new req arriving at the release edge is considered in the following IDLE cycle.
//   - done bits of non-holders are ignored.
//   - done[h]=1 in the grant cycle itself is not possible: done is sampled only in GRANT.
//  Fairness: ptr moves only on release. A port with req held high waits at most
//   (N-1)*(MAX_HOLD+1) cycles when MAX_HOLD!=0.
//  Integrity check, evaluated every cycle after reset:
//   - parity_err goes to 1 if grant_valid=1 and grant_parity=0.
//   - parity_err goes to 1 if grant_valid=0 and grant_parity=1.
//   - parity_err is cleared only by rst.
//   - Arbiter state is not affected by the error.
//  Index arithmetic: ptr and the scan are IDX_W bits and wrap naturally mod N,
//   since N is a power of two.
// TESTING
//  1 Reset then idle:
//    rst 2 cycles, req=0 -> grant=0, grant_valid=0, parity_err=0 for 20 cycles.
//  2 Single request:
//    req=8'h04 at cycle 0 -> cycle 1 grant=8'h04, grant_idx=2.
//    done[2] pulse at cycle 5 -> cycle 6 grant=0, and ptr=3.
//  3 Round robin:
//    req=8'h81 held, each holder pulses done after 3 cycles.
//    -> grants alternate 8'h01, 8'h80, 8'h01, ... with a 1-cycle gap between each.
//  4 Max-hold preemption (MAX_HOLD=16):
//    req=8'h03 held, no done -> port0 is granted for 16 cycles, then released.
//    Port1 is granted 2 cycles after the release edge.
//    With req=8'h01 only, port0 holds indefinitely.
//  5 Reset mid-grant:
//    rst asserted while grant=8'h10 -> next cycle all outputs and ptr are 0.
//    With req=8'h10 still held, grant=8'h10 returns 1 cycle after rst deasserts.
//  6 Parity fault:
//    force grant_parity=0 during a grant -> parity_err=1 the next cycle.
//    It stays 1 after the grant ends and clears only on rst.

Source files
------------

// File: rtl/mux_sel_arbiter_if.sv
// Bus bundle between the shared-memory mux arbiter and its requesters.
// The slave side is the arbiter: it takes requests and the parity returned
// by the xor_tree, and drives the one-hot mux select and status.
interface mux_sel_arbiter_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
);
  logic [N-1:0]     req;
  logic [N-1:0]     done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             grant_parity;
  logic             parity_err;

  modport master (
    output req, done, grant_parity,
    input  grant, grant_idx, grant_valid, parity_err
  );

  modport slave (
    input  req, done, grant_parity,
    output grant, grant_idx, grant_valid, parity_err
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for one shared-memory output mux.
// Holds a registered one-hot grant for one port at a time, always inserts one
// idle cycle between grants, optionally preempts a long holder when others
// wait, and checks the returned grant parity as a one-hot integrity test.
module mux_sel_arbiter #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst,
  mux_sel_arbiter_if.slave  bus
);

  // Hold counter only needs to reach MAX_HOLD-1.
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    (MAX_HOLD == 0) ? {HOLD_W{1'b0}} : HOLD_W'(MAX_HOLD - 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  // First set request scanning from p upwards, wrapping mod N.
  // Returns {found, index}.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDX_W-1:0] p);
    logic             found;
    logic [IDX_W-1:0] w;
    logic [IDX_W-1:0] idx;
    found = 1'b0;
    w     = p;
    for (int i = 0; i < N; i++) begin
      idx = p + IDX_W'(i);
      if (!found && r[idx]) begin
        found = 1'b1;
        w     = idx;
      end else begin
        found = found;
        w     = w;
      end
    end
    return {found, w};
  endfunction

  // One-hot decode of a port index.
  function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  // A valid one-hot grant has odd parity; an idle (all-zero) grant has even.
  function automatic logic integrity_fault(input logic valid, input logic parity);
    return valid ^ parity;
  endfunction

  logic [0:0]        state_r,       state_s;
  logic [IDX_W-1:0]  ptr_r,         ptr_s;
  logic [HOLD_W-1:0] hold_cnt_r,    hold_cnt_s;
  logic [N-1:0]      grant_r,       grant_s;
  logic [IDX_W-1:0]  grant_idx_r,   grant_idx_s;
  logic              grant_valid_r, grant_valid_s;
  logic              parity_err_r;

  logic [IDX_W:0]    pick_s;
  logic [N-1:0]      holder_mask_s;
  logic              others_s;
  logic              hold_expired_s;
  logic              release_s;

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_s       = state_r;
    ptr_s         = ptr_r;
    hold_cnt_s    = hold_cnt_r;
    grant_s       = grant_r;
    grant_idx_s   = grant_idx_r;
    grant_valid_s = grant_valid_r;

    pick_s         = rr_pick(bus.req, ptr_r);
    holder_mask_s  = onehot(grant_idx_r);
    others_s       = |(bus.req & ~holder_mask_s);
    hold_expired_s = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST) && others_s;
    release_s      = bus.done[grant_idx_r] | ~bus.req[grant_idx_r] | hold_expired_s;

    case (state_r)
      ST_IDLE: begin
        if (pick_s[IDX_W]) begin
          state_s       = ST_GRANT;
          grant_s       = onehot(pick_s[IDX_W-1:0]);
          grant_idx_s   = pick_s[IDX_W-1:0];
          grant_valid_s = 1'b1;
          hold_cnt_s    = {HOLD_W{1'b0}};
        end else begin
          state_s       = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          // grant_idx deliberately keeps the last holder.
          state_s       = ST_IDLE;
          grant_s       = {N{1'b0}};
          grant_valid_s = 1'b0;
          ptr_s         = grant_idx_r + IDX_W'(1);
          hold_cnt_s    = {HOLD_W{1'b0}};
        end else if (hold_cnt_r != HOLD_LAST) begin
          hold_cnt_s    = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_s    = hold_cnt_r;
        end
      end
      default: begin
        state_s       = ST_IDLE;
        grant_s       = {N{1'b0}};
        grant_valid_s = 1'b0;
        hold_cnt_s    = {HOLD_W{1'b0}};
      end
    endcase
  end

  // State, output and sticky integrity-flag registers; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ptr_r         <= {IDX_W{1'b0}};
      hold_cnt_r    <= {HOLD_W{1'b0}};
      grant_r       <= {N{1'b0}};
      grant_idx_r   <= {IDX_W{1'b0}};
      grant_valid_r <= 1'b0;
      parity_err_r  <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      hold_cnt_r    <= hold_cnt_s;
      grant_r       <= grant_s;
      grant_idx_r   <= grant_idx_s;
      grant_valid_r <= grant_valid_s;
      parity_err_r  <= parity_err_r | integrity_fault(grant_valid_r, bus.grant_parity);
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_idx   = grant_idx_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.parity_err  = parity_err_r;

endmodule
